// File: rtl/monitor_pkg.sv
// monitor_pkg
// Shared definitions for the monitor active-device counter and the scheduler
// that drives it.
//   DEF_W          default counter width, matches monitor.counter_out
//   DEF_MAX_COUNT  default capacity; a join at this count is refused
//   sched_state_e  scheduler FSM states
package monitor_pkg;

  localparam int DEF_W         = 8;
  localparam int DEF_MAX_COUNT = 255;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter. It picks the lowest-numbered active
// request at or above ptr. If there is none, it wraps around and picks the
// lowest-numbered active request overall.
// Ports:
//   req    [N-1:0]   active requests
//   ptr    [PW-1:0]  port with the highest priority this cycle
//   gnt    [N-1:0]   one-hot grant, zero when no request is active
//   valid            at least one request is active
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  logic [N-1:0] upper_mask;
  logic [N-1:0] upper_req;

  // Ports at or above ptr take priority. The expression x & (~x + 1)
  // isolates the lowest set bit, which gives the one-hot winner without any
  // indexed loop.
  always_comb begin
    upper_mask = ~((N'(1) << ptr) - N'(1));
    upper_req  = req & upper_mask;
    if (upper_req != '0) begin
      gnt = upper_req & (~upper_req + N'(1));
    end else begin
      gnt = req & (~req + N'(1));
    end
    valid = |req;
  end

endmodule

// File: rtl/monitor_scheduler.sv
// monitor_scheduler
// Round-robin scheduler that shares one monitor active-device counter among
// N gateway ports. It grants at most one join/leave per cycle and keeps a
// shadow count, so a join at capacity or a leave at zero is refused instead
// of wrapping. It also sequences the monitor's synchronous reset after
// power-up and on a software clear.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req  [N-1:0]      per-port request level, held until ack or nack
//   dir  [N-1:0]      per-port direction, 1 = join, 0 = leave
//   clear             single-cycle pulse that zeroes the count
//   ack  [N-1:0]      one-hot pulse, request issued to the monitor
//   nack [N-1:0]      one-hot pulse, request refused (full or empty)
//   mon_rst           drives monitor.rst
//   mon_change        drives monitor.change
//   mon_on_off        drives monitor.on_off
//   count [W-1:0]     shadow of monitor.counter_out
//   busy              high in INIT and CLEAR; requests are not serviced
module monitor_scheduler
  import monitor_pkg::*;
#(
  parameter int N         = 4,
  parameter int W         = DEF_W,
  parameter int MAX_COUNT = DEF_MAX_COUNT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] dir,
  input  logic         clear,
  output logic [N-1:0] ack,
  output logic [N-1:0] nack,
  output logic         mon_rst,
  output logic         mon_change,
  output logic         mon_on_off,
  output logic [W-1:0] count,
  output logic         busy
);

  localparam int            PW        = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0]  MAX_W     = W'(MAX_COUNT);
  localparam logic [PW-1:0] LAST_PORT = PW'(N - 1);

  sched_state_e state;
  sched_state_e next_state;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_d;

  logic [N-1:0]  gnt;
  logic          gnt_valid;
  logic          gnt_dir;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] idx_chain [N];

  logic [N-1:0]  ack_d;
  logic [N-1:0]  nack_d;
  logic          mon_rst_d;
  logic          mon_change_d;
  logic          mon_on_off_d;
  logic          busy_d;
  logic [W-1:0]  count_d;

  rr_arbiter #(
    .N  (N),
    .PW (PW)
  ) u_arb (
    .req   (req),
    .ptr   (ptr),
    .gnt   (gnt),
    .valid (gnt_valid)
  );

  // Turn the one-hot grant into a port index. An OR chain over the grant
  // bits is enough because at most one bit is set.
  for (genvar i = 0; i < N; i++) begin : g_enc
    if (i == 0) begin : g_first
      assign idx_chain[i] = gnt[i] ? PW'(i) : '0;
    end else begin : g_rest
      assign idx_chain[i] = idx_chain[i-1] | (gnt[i] ? PW'(i) : '0);
    end
  end
  assign gnt_idx = idx_chain[N-1];

  // Direction of the winning port. dir is stable while req is high.
  assign gnt_dir = |(gnt & dir);

  // State register. INIT is held for as long as rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. INIT lasts one cycle after reset is released, so the
  // monitor sees mon_rst on at least one rising edge. A clear while not in
  // RUN is ignored.
  always_comb begin
    next_state = state;
    unique case (state)
      INIT:    next_state = RUN;
      RUN:     next_state = clear ? CLEAR : RUN;
      CLEAR:   next_state = RUN;
      default: next_state = INIT;
    endcase
  end

  // Output and datapath decode. All outputs are registered below.
  // mon_rst and busy follow the state being entered. A grant happens only
  // when the FSM stays in RUN, so mon_change can never coincide with
  // mon_rst; this matters because the monitor's reset does not override its
  // decrement path. A clear in RUN suppresses that cycle's grant, so the
  // requester stays pending and is served once RUN resumes.
  always_comb begin
    ack_d        = '0;
    nack_d       = '0;
    mon_change_d = 1'b0;
    mon_on_off_d = 1'b0;
    count_d      = count;
    ptr_d        = ptr;
    mon_rst_d    = (next_state != RUN);
    busy_d       = (next_state != RUN);
    if (state == RUN) begin
      if (clear) begin
        count_d = '0;
      end else if (gnt_valid) begin
        ptr_d = (gnt_idx == LAST_PORT) ? '0 : gnt_idx + PW'(1);
        if (gnt_dir) begin
          if (count < MAX_W) begin
            ack_d        = gnt;
            mon_change_d = 1'b1;
            mon_on_off_d = 1'b1;
            count_d      = count + W'(1);
          end else begin
            nack_d = gnt;
          end
        end else begin
          if (count != '0) begin
            ack_d        = gnt;
            mon_change_d = 1'b1;
            mon_on_off_d = 1'b0;
            count_d      = count - W'(1);
          end else begin
            nack_d = gnt;
          end
        end
      end
    end
  end

  // Output registers, round-robin pointer and shadow count. Reset holds the
  // monitor in reset and marks the scheduler busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack        <= '0;
      nack       <= '0;
      mon_rst    <= 1'b1;
      mon_change <= 1'b0;
      mon_on_off <= 1'b0;
      count      <= '0;
      busy       <= 1'b1;
      ptr        <= '0;
    end else begin
      ack        <= ack_d;
      nack       <= nack_d;
      mon_rst    <= mon_rst_d;
      mon_change <= mon_change_d;
      mon_on_off <= mon_on_off_d;
      count      <= count_d;
      busy       <= busy_d;
      ptr        <= ptr_d;
    end
  end

endmodule

// File: tb/tb_monitor_scheduler.sv
// tb_monitor_scheduler
// Directed bench for monitor_scheduler. Unit 0 uses the default capacity.
// Unit 1 uses MAX_COUNT = 3, so a join at capacity can be reached, and it
// drives a small behavioural monitor counter. Expected outputs are queued
// when stimulus is driven and compared after the next rising edge.
module tb_monitor_scheduler;

  typedef struct packed {
    logic       unit;
    logic [3:0] ack;
    logic [3:0] nack;
    logic       mon_rst;
    logic       chg;
    logic       onoff;
    logic [7:0] cnt;
    logic       busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic [3:0] req0, dir0, ack0, nack0;
  logic       clear0, mon_rst0, chg0, oo0, busy0;
  logic [7:0] cnt0;

  logic [3:0] req1, dir1, ack1, nack1;
  logic       clear1, mon_rst1, chg1, oo1, busy1;
  logic [7:0] cnt1;

  logic [7:0] mon1;

  int    vectors     = 0;
  int    miscompares = 0;
  exp_t  sb[$];
  string tags[$];

  always #5 clk = ~clk;

  monitor_scheduler #(.N(4), .W(8), .MAX_COUNT(255)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .dir(dir0), .clear(clear0),
    .ack(ack0), .nack(nack0), .mon_rst(mon_rst0), .mon_change(chg0),
    .mon_on_off(oo0), .count(cnt0), .busy(busy0)
  );

  monitor_scheduler #(.N(4), .W(8), .MAX_COUNT(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .dir(dir1), .clear(clear1),
    .ack(ack1), .nack(nack1), .mon_rst(mon_rst1), .mon_change(chg1),
    .mon_on_off(oo1), .count(cnt1), .busy(busy1)
  );

  // Behavioural monitor attached to unit 1 (synchronous active-high reset)
  always @(posedge clk) begin
    if (mon_rst1) mon1 <= 8'd0;
    else if (chg1) mon1 <= oo1 ? mon1 + 8'd1 : mon1 - 8'd1;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic exp_t mk(input logic u, input logic [3:0] a,
                              input logic [3:0] n, input logic r,
                              input logic ch, input logic oo,
                              input logic [7:0] c, input logic b);
    exp_t e;
    e.unit = u; e.ack = a; e.nack = n; e.mon_rst = r;
    e.chg = ch; e.onoff = oo; e.cnt = c; e.busy = b;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compareOutputs(input string tag, input exp_t e);
    logic [3:0] a, n;
    logic       r, ch, oo, b;
    logic [7:0] c;
    if (e.unit) begin
      a = ack1; n = nack1; r = mon_rst1; ch = chg1; oo = oo1; c = cnt1; b = busy1;
    end else begin
      a = ack0; n = nack0; r = mon_rst0; ch = chg0; oo = oo0; c = cnt0; b = busy0;
    end
    chk({tag, ".ack"},        32'(a),  32'(e.ack));
    chk({tag, ".nack"},       32'(n),  32'(e.nack));
    chk({tag, ".mon_rst"},    32'(r),  32'(e.mon_rst));
    chk({tag, ".mon_change"}, 32'(ch), 32'(e.chg));
    chk({tag, ".mon_on_off"}, 32'(oo), 32'(e.onoff));
    chk({tag, ".count"},      32'(c),  32'(e.cnt));
    chk({tag, ".busy"},       32'(b),  32'(e.busy));
  endtask

  task automatic applyStimulus(input string tag, input exp_t e,
                               input logic [3:0] r, input logic [3:0] d,
                               input logic c);
    @(negedge clk);
    req0 = 4'b0; dir0 = 4'b0; clear0 = 1'b0;
    req1 = 4'b0; dir1 = 4'b0; clear1 = 1'b0;
    if (e.unit) begin
      req1 = r; dir1 = d; clear1 = c;
    end else begin
      req0 = r; dir0 = d; clear0 = c;
    end
    sb.push_back(e);
    tags.push_back(tag);
  endtask

  task automatic checkOutput();
    exp_t  e;
    string t;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    t = tags.pop_front();
    compareOutputs(t, e);
  endtask

  task automatic step(input string tag, input exp_t e, input logic [3:0] r,
                      input logic [3:0] d, input logic c);
    applyStimulus(tag, e, r, d, c);
    checkOutput();
  endtask

  initial begin
    req0 = 4'b0; dir0 = 4'b0; clear0 = 1'b0;
    req1 = 4'b0; dir1 = 4'b0; clear1 = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    compareOutputs("reset", mk(0, 4'b0, 4'b0, 1, 0, 0, 8'd0, 1));
    compareOutputs("reset_u1", mk(1, 4'b0, 4'b0, 1, 0, 0, 8'd0, 1));

    // Release reset between edges: INIT lasts until the next rising edge
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compareOutputs("init_hold", mk(0, 4'b0, 4'b0, 1, 0, 0, 8'd0, 1));
    sb.push_back(mk(0, 4'b0, 4'b0, 0, 0, 0, 8'd0, 0));
    tags.push_back("init_exit");
    checkOutput();

    // Round robin, all ports joining, held for 8 cycles
    for (int i = 0; i < 8; i++) begin
      step("rr", mk(0, 4'(1 << (i % 4)), 4'b0, 0, 1, 1, 8'(i + 1), 0),
           4'b1111, 4'b1111, 1'b0);
    end

    // Clear with nothing pending
    step("clr_a", mk(0, 4'b0, 4'b0, 1, 0, 0, 8'd0, 1), 4'b0, 4'b0, 1'b1);
    step("clr_b", mk(0, 4'b0, 4'b0, 0, 0, 0, 8'd0, 0), 4'b0, 4'b0, 1'b0);

    // Leave at zero is refused; ptr still moves on to port 3
    step("empty_nack", mk(0, 4'b0, 4'b0100, 0, 0, 0, 8'd0, 0), 4'b0100, 4'b0000, 1'b0);
    step("ptr3", mk(0, 4'b1000, 4'b0, 0, 1, 1, 8'd1, 0), 4'b1001, 4'b1001, 1'b0);
    step("ptr0", mk(0, 4'b0001, 4'b0, 0, 1, 1, 8'd2, 0), 4'b1001, 4'b1001, 1'b0);
    step("leave", mk(0, 4'b0010, 4'b0, 0, 1, 0, 8'd1, 0), 4'b0010, 4'b0000, 1'b0);

    // Fill to 5, starting from ptr = 2
    step("fill", mk(0, 4'b0100, 4'b0, 0, 1, 1, 8'd2, 0), 4'b1111, 4'b1111, 1'b0);
    step("fill", mk(0, 4'b1000, 4'b0, 0, 1, 1, 8'd3, 0), 4'b1111, 4'b1111, 1'b0);
    step("fill", mk(0, 4'b0001, 4'b0, 0, 1, 1, 8'd4, 0), 4'b1111, 4'b1111, 1'b0);
    step("fill", mk(0, 4'b0010, 4'b0, 0, 1, 1, 8'd5, 0), 4'b1111, 4'b1111, 1'b0);

    // Clear during contention; a second clear while in CLEAR is ignored
    step("cc_clear", mk(0, 4'b0, 4'b0, 1, 0, 0, 8'd0, 1), 4'b0011, 4'b0011, 1'b1);
    step("cc_inclear", mk(0, 4'b0, 4'b0, 0, 0, 0, 8'd0, 0), 4'b0011, 4'b0011, 1'b1);
    step("cc_port0", mk(0, 4'b0001, 4'b0, 0, 1, 1, 8'd1, 0), 4'b0011, 4'b0011, 1'b0);
    step("cc_port1", mk(0, 4'b0010, 4'b0, 0, 1, 1, 8'd2, 0), 4'b0011, 4'b0011, 1'b0);

    // Asynchronous reset between edges during grants
    step("pre_arst", mk(0, 4'b0100, 4'b0, 0, 1, 1, 8'd3, 0), 4'b1111, 4'b1111, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    compareOutputs("arst", mk(0, 4'b0, 4'b0, 1, 0, 0, 8'd0, 1));
    req0 = 4'b0; dir0 = 4'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(mk(0, 4'b0, 4'b0, 0, 0, 0, 8'd0, 0));
    tags.push_back("arst_exit");
    checkOutput();
    step("arst_ptr0", mk(0, 4'b0001, 4'b0, 0, 1, 1, 8'd1, 0), 4'b1111, 4'b1111, 1'b0);
    step("idle", mk(0, 4'b0, 4'b0, 0, 0, 0, 8'd1, 0), 4'b0, 4'b0, 1'b0);

    // Full reject on the MAX_COUNT = 3 unit
    step("full_j1", mk(1, 4'b0001, 4'b0, 0, 1, 1, 8'd1, 0), 4'b0001, 4'b0001, 1'b0);
    step("full_j2", mk(1, 4'b0001, 4'b0, 0, 1, 1, 8'd2, 0), 4'b0001, 4'b0001, 1'b0);
    step("full_j3", mk(1, 4'b0001, 4'b0, 0, 1, 1, 8'd3, 0), 4'b0001, 4'b0001, 1'b0);
    step("full_nack", mk(1, 4'b0, 4'b0001, 0, 0, 0, 8'd3, 0), 4'b0001, 4'b0001, 1'b0);
    step("full_idle", mk(1, 4'b0, 4'b0, 0, 0, 0, 8'd3, 0), 4'b0, 4'b0, 1'b0);
    chk("monitor_count", 32'(mon1), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
